fir_out_sink: RTL and testbench
===============================

Name: fir_out_sink

Overview:
Receiving end of the FIR output stream. The FIR core's master port (34-bit tdata, tvalid only, no tready) cannot be back-pressured, so this block absorbs it. Each sample is rounded and saturated to a 16-bit result and buffered in a small first-word-fall-through (FWFT) FIFO. The FIFO drives a full AXI-Stream master (tvalid/tready) toward downstream consumers such as a DAC or UART framer. Overflow is detected and flagged, never silently hidden.

Parameters:
IN_W, 34, input sample width (two's complement)
OUT_W, 16, output sample width (two's complement)
SHIFT, 15, arithmetic right shift applied before rounding (coefficient Q-format); must satisfy 1 <= SHIFT < IN_W
DEPTH, 16, FIFO depth in entries; power of two, >= 4
ADDR_W, 4, log2(DEPTH)

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  asynchronous, active-high reset
s_axis_data_tvalid  in  1  FIR output valid; no ready is returned
s_axis_data_tdata  in  IN_W  FIR output sample
m_axis_data_tvalid  out  1  output sample available
m_axis_data_tready  in  1  downstream accepts
m_axis_data_tdata  out  OUT_W  rounded/saturated sample
fill_level  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH
ovf_flag  out  1  sticky overflow indicator
ovf_clr  in  1  synchronous clear of ovf_flag
drop_count  out  16  dropped-sample counter; present only with FIR_SINK_STATS_EN

Behaviour:
- Reset (async assert, sync release): all pointers, fill_level, ovf_flag, the stage register valid bit and drop_count go to 0. m_axis_data_tvalid=0. m_axis_data_tdata=0. FIFO memory contents are not reset.
- Stage 1 (conditioning register): on an edge with s_axis_data_tvalid=1, capture the conditioned sample and set stg_vld=1; otherwise stg_vld=0. Conditioning:
  - Sign-extend the input to IN_W+1 bits.
  - Add 2^(SHIFT-1), which rounds half toward +inf.
  - Arithmetic right shift by SHIFT.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Stage 2 (FIFO write):
  - pop = m_axis_data_tvalid & m_axis_data_tready.
  - wr_ok = stg_vld & (fill_level<DEPTH | pop).
  - Simultaneous push and pop when full is accepted; fill_level is then unchanged.
  - Push and pop in the same cycle at any level leave fill_level unchanged.
- Latency: sample presented at edge N is visible on m_axis_data_tdata with tvalid=1 after edge N+2, given an empty FIFO.
- Output: FWFT.
  - m_axis_data_tvalid = (fill_level!=0).
  - m_axis_data_tdata = mem[rd_ptr]; it is held stable while tvalid=1 and tready=0.
  - tvalid never drops without a pop.
- Pointers: wr_ptr and rd_ptr are ADDR_W bits and wrap DEPTH-1 -> 0 naturally.
- Overflow: stg_vld=1 while full and no pop means the sample is dropped, not written, and ovf_flag sets at that edge.
  - ovf_clr=1 clears ovf_flag.
  - If a drop coincides with ovf_clr, set wins and the flag stays 1.
- Input tvalid may be asserted every cycle. Sustained rate is 1 sample/clk provided the downstream tready is continuous.
- An areset assertion mid-stream discards FIFO contents and the in-flight stage sample. tvalid falls immediately (async).

Optional Feature:
Macro FIR_SINK_STATS_EN.
- Defined: port drop_count is present. It increments by 1 on every dropped sample, saturates at 16'hFFFF, and clears on reset or ovf_clr. A drop coinciding with ovf_clr yields drop_count=1.
- Undefined: the port and counter are absent; ovf_flag alone reports overflow. All other behaviour is identical.

Decomposition:
- Shared package fir_pkg holds:
  - FIR_IN_W=34, FIR_OUT_W=16, FIR_SHIFT=15;
  - a function or constant for the saturation limits (SAT_MAX, SAT_MIN);
  - the sample_t typedef (OUT_W signed).
- One sub-module: fir_sync_fifo. It is a parameterised FWFT FIFO with push, pop, full, empty and count signals. Rounding/saturation and overflow logic stay in the top.

Test Plan:
- Rounding: inputs 32768, 16384, 16383, -16384, -16385 each with tready=1 -> outputs 1, 1, 0, 0, -1 in order, each 2 cycles after input.
- Saturation: inputs 2^31 and -2^31 -> outputs 32767 and -32768; input 32767*32768 -> 32767 exactly.
- Back-pressure/fill: hold tready=0 and push 16 consecutive samples 1..16 (scaled by 32768).
  - Expected: fill_level=16, ovf_flag=0.
  - Then release tready -> outputs 1..16 in order, tdata stable while stalled.
- Overflow: with the FIFO full and tready=0, push 3 more samples -> ovf_flag=1, drop_count=3 (with the macro), fill_level stays 16 and the dropped values never appear. Pulse ovf_clr -> flag and counter return to 0.
- Full + simultaneous pop: FIFO full, tready=1 and input valid in the same cycle -> sample accepted, no overflow, fill_level stays 16.
- Reset mid-stream: assert areset with fill_level=7 -> tvalid=0 and fill_level=0 immediately. After release, a new input 65536 -> output 2.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR output path: widths, Q-format shift,
// the 16-bit sample type and the saturation limits used by the output sink.
package fir_pkg;

    localparam int FIR_IN_W   = 34;
    localparam int FIR_OUT_W  = 16;
    localparam int FIR_SHIFT  = 15;
    localparam int FIR_DEPTH  = 16;
    localparam int FIR_ADDR_W = 4;

    typedef logic signed [FIR_OUT_W-1:0] sample_t;

    localparam sample_t SAT_MAX = sample_t'({1'b0, {(FIR_OUT_W-1){1'b1}}});
    localparam sample_t SAT_MIN = sample_t'({1'b1, {(FIR_OUT_W-1){1'b0}}});

    // Saturation bound for a w-bit two's-complement result (upper or lower).
    function automatic longint sat_limit(input int w, input bit upper);
        longint lim;
        if (upper) begin
            lim = (64'sd1 <<< (w - 1)) - 64'sd1;
        end else begin
            lim = -(64'sd1 <<< (w - 1));
        end
        return lim;
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Parameterised first-word-fall-through synchronous FIFO; head entry is
// presented on rdata whenever the FIFO is non-empty, zero otherwise.
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH  = FIR_OUT_W,
    parameter int DEPTH  = FIR_DEPTH,
    parameter int ADDR_W = FIR_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full  = (count_r == (ADDR_W+1)'(DEPTH));
    assign empty = (count_r == {(ADDR_W+1){1'b0}});
    assign count = count_r;

    // A pop frees the slot in the same edge, so a full FIFO may still accept a push.
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Read/write pointers, wrapping naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
            end
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {(ADDR_W+1){1'b0}};
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (ADDR_W+1)'(1);
                2'b01:   count_r <= count_r - (ADDR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FWFT head; driven to zero while empty so the output never shows stale data.
    always_comb begin
        if (empty) begin
            rdata = {WIDTH{1'b0}};
        end else begin
            rdata = mem_r[rd_ptr_r];
        end
    end

endmodule

// File: rtl/fir_out_sink.sv
// FIR output sink: rounds/saturates the 34-bit FIR stream to 16 bits and buffers
// it in an FWFT FIFO feeding an AXI-Stream master. Macro FIR_SINK_STATS_EN adds drop_count.
module fir_out_sink
    import fir_pkg::*;
#(
    parameter int IN_W   = FIR_IN_W,
    parameter int OUT_W  = FIR_OUT_W,
    parameter int SHIFT  = FIR_SHIFT,
    parameter int DEPTH  = FIR_DEPTH,
    parameter int ADDR_W = FIR_ADDR_W
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              s_axis_data_tvalid,
    input  logic [IN_W-1:0]   s_axis_data_tdata,
    output logic              m_axis_data_tvalid,
    input  logic              m_axis_data_tready,
    output logic [OUT_W-1:0]  m_axis_data_tdata,
    output logic [ADDR_W:0]   fill_level,
    input  logic              ovf_clr,
    output logic              ovf_flag
`ifdef FIR_SINK_STATS_EN
    ,
    output logic [15:0]       drop_count
`endif
);

    localparam int EXT_W = IN_W + 1;
    localparam int RES_W = EXT_W - SHIFT;

    localparam logic signed [EXT_W-1:0] HALF_LSB = EXT_W'(1) << (SHIFT - 1);
    localparam logic signed [RES_W-1:0] LIM_HI   = RES_W'(sat_limit(OUT_W, 1'b1));
    localparam logic signed [RES_W-1:0] LIM_LO   = RES_W'(sat_limit(OUT_W, 1'b0));

    logic signed [EXT_W-1:0] ext_s;
    logic signed [EXT_W-1:0] rnd_s;
    logic signed [RES_W-1:0] res_s;
    logic [OUT_W-1:0]        cond_s;

    logic                    stg_vld_r;
    logic [OUT_W-1:0]        stg_data_r;

    logic                    pop_s;
    logic                    wr_ok_s;
    logic                    drop_s;
    logic                    full_s;
    logic                    empty_s;
    logic                    ovf_r;

    // Sample conditioning: one extra sign bit keeps the rounding add from overflowing.
    always_comb begin
        ext_s = {s_axis_data_tdata[IN_W-1], s_axis_data_tdata};
        rnd_s = ext_s + HALF_LSB;
        res_s = RES_W'(rnd_s >>> SHIFT);
        if (res_s > LIM_HI) begin
            cond_s = LIM_HI[OUT_W-1:0];
        end else if (res_s < LIM_LO) begin
            cond_s = LIM_LO[OUT_W-1:0];
        end else begin
            cond_s = res_s[OUT_W-1:0];
        end
    end

    // Conditioning stage register; valid follows the input every cycle.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            stg_vld_r  <= 1'b0;
            stg_data_r <= {OUT_W{1'b0}};
        end else begin
            stg_vld_r <= s_axis_data_tvalid;
            if (s_axis_data_tvalid) begin
                stg_data_r <= cond_s;
            end
        end
    end

    assign pop_s   = m_axis_data_tvalid & m_axis_data_tready;
    assign wr_ok_s = stg_vld_r & (~full_s | pop_s);
    assign drop_s  = stg_vld_r & full_s & ~pop_s;

    fir_sync_fifo #(
        .WIDTH  (OUT_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk    (aclk),
        .rst    (areset),
        .push   (wr_ok_s),
        .pop    (pop_s),
        .wdata  (stg_data_r),
        .rdata  (m_axis_data_tdata),
        .full   (full_s),
        .empty  (empty_s),
        .count  (fill_level)
    );

    assign m_axis_data_tvalid = ~empty_s;

    // Sticky overflow flag; a drop in the same edge as a clear keeps it set.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign ovf_flag = ovf_r;

`ifdef FIR_SINK_STATS_EN
    logic [15:0] drop_cnt_r;

    // Saturating dropped-sample counter; a drop coinciding with clear restarts at one.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            drop_cnt_r <= 16'h0000;
        end else if (ovf_clr) begin
            drop_cnt_r <= drop_s ? 16'h0001 : 16'h0000;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign drop_count = drop_cnt_r;
`endif

endmodule

// File: tb/tb_fir_out_sink.sv
// Self-checking bench for fir_out_sink: directed scenarios plus randomized traffic
// compared against a queue-based transaction model of the sink.
module tb_fir_out_sink;

    logic        aclk = 1'b0;
    logic        areset;
    logic        s_axis_data_tvalid;
    logic [33:0] s_axis_data_tdata;
    logic        m_axis_data_tvalid;
    logic        m_axis_data_tready;
    logic [15:0] m_axis_data_tdata;
    logic [4:0]  fill_level;
    logic        ovf_clr;
    logic        ovf_flag;
`ifdef FIR_SINK_STATS_EN
    logic [15:0] drop_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int mq[$];
    bit m_stg_v;
    int m_stg_d;
    bit m_ovf;
    int m_dc;

    always #5 aclk = ~aclk;

    fir_out_sink dut (
        .aclk               (aclk),
        .areset             (areset),
        .s_axis_data_tvalid (s_axis_data_tvalid),
        .s_axis_data_tdata  (s_axis_data_tdata),
        .m_axis_data_tvalid (m_axis_data_tvalid),
        .m_axis_data_tready (m_axis_data_tready),
        .m_axis_data_tdata  (m_axis_data_tdata),
        .fill_level         (fill_level),
        .ovf_clr            (ovf_clr),
        .ovf_flag           (ovf_flag)
`ifdef FIR_SINK_STATS_EN
        ,
        .drop_count         (drop_count)
`endif
    );

    // Round half toward +inf after dividing by 2^15, then clamp to 16-bit range.
    function automatic int ref_cond(input logic [33:0] d);
        longint v;
        longint num;
        longint q;
        v   = longint'($signed(d));
        num = v + 64'sd16384;
        q   = num / 64'sd32768;
        if (num < 0 && (num % 64'sd32768) != 0) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_stg_v = 1'b0;
        m_stg_d = 0;
        m_ovf   = 1'b0;
        m_dc    = 0;
    endtask

    // Advance the model by one clock using the currently driven inputs, then step the DUT.
    task automatic tick();
        bit pop;
        bit drop;
        int dummy;
        int sz;
        sz   = mq.size();
        pop  = (sz != 0) && (m_axis_data_tready == 1'b1);
        drop = 1'b0;
        if (pop) dummy = mq.pop_front();
        if (m_stg_v) begin
            if (sz < 16 || pop) mq.push_back(m_stg_d);
            else drop = 1'b1;
        end
        if (drop) begin
            m_ovf = 1'b1;
            if (ovf_clr) m_dc = 1;
            else if (m_dc < 65535) m_dc = m_dc + 1;
        end else if (ovf_clr) begin
            m_ovf = 1'b0;
            m_dc  = 0;
        end
        m_stg_v = s_axis_data_tvalid;
        m_stg_d = ref_cond(s_axis_data_tdata);
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        areset             = 1'b1;
        s_axis_data_tvalid = 1'b0;
        s_axis_data_tdata  = 34'd0;
        m_axis_data_tready = 1'b0;
        ovf_clr            = 1'b0;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        model_reset();
    endtask

    task automatic push_seq(input int first, input int n);
        for (int k = 0; k < n; k++) begin
            s_axis_data_tvalid = 1'b1;
            s_axis_data_tdata  = 34'(longint'(first + k) * 64'sd32768);
            tick();
        end
        s_axis_data_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        areset             = 1'b1;
        s_axis_data_tvalid = 1'b1;
        s_axis_data_tdata  = 34'd32768;
        m_axis_data_tready = 1'b1;
        ovf_clr            = 1'b0;
        #22;
        n_checks++;
        if (m_axis_data_tvalid !== 1'b0) begin n_errors++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_data_tvalid); end
        n_checks++;
        if (m_axis_data_tdata !== 16'd0) begin n_errors++; $display("FAIL reset_tdata: got %0h expected 0", m_axis_data_tdata); end
        n_checks++;
        if (fill_level !== 5'd0) begin n_errors++; $display("FAIL reset_fill: got %0d expected 0", fill_level); end
        n_checks++;
        if (ovf_flag !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b expected 0", ovf_flag); end
`ifdef FIR_SINK_STATS_EN
        n_checks++;
        if (drop_count !== 16'd0) begin n_errors++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
`endif
        do_reset();
    endtask

    task automatic test_rounding();
        int ins[5]   = '{32768, 16384, 16383, -16384, -16385};
        int exp_v[5] = '{1, 1, 0, 0, -1};
        do_reset();
        m_axis_data_tready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) begin
                s_axis_data_tvalid = 1'b1;
                s_axis_data_tdata  = 34'(ins[i]);
            end else begin
                s_axis_data_tvalid = 1'b0;
            end
            tick();
            if (i >= 1 && i <= 5) begin
                n_checks++;
                if (m_axis_data_tvalid !== 1'b1 || m_axis_data_tdata !== 16'(exp_v[i-1])) begin
                    n_errors++;
                    $display("FAIL round_%0d: got v=%b d=%0d expected v=1 d=%0d", i - 1, m_axis_data_tvalid, $signed(m_axis_data_tdata), exp_v[i-1]);
                end
            end else begin
                n_checks++;
                if (m_axis_data_tvalid !== 1'b0) begin n_errors++; $display("FAIL round_idle_%0d: got tvalid %b expected 0", i, m_axis_data_tvalid); end
            end
        end
    endtask

    task automatic test_saturation();
        longint ins[3] = '{64'sd2147483648, -64'sd2147483648, 64'sd1073709056};
        int exp_v[3]   = '{32767, -32768, 32767};
        do_reset();
        m_axis_data_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                s_axis_data_tvalid = 1'b1;
                s_axis_data_tdata  = 34'(ins[i]);
            end else begin
                s_axis_data_tvalid = 1'b0;
            end
            tick();
            if (i >= 1) begin
                n_checks++;
                if (m_axis_data_tvalid !== 1'b1 || m_axis_data_tdata !== 16'(exp_v[i-1])) begin
                    n_errors++;
                    $display("FAIL sat_%0d: got v=%b d=%0d expected v=1 d=%0d", i - 1, m_axis_data_tvalid, $signed(m_axis_data_tdata), exp_v[i-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        m_axis_data_tready = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            s_axis_data_tvalid = 1'b1;
            s_axis_data_tdata  = 34'(longint'(k) * 64'sd32768);
            tick();
            if (k >= 2) begin
                n_checks++;
                if (m_axis_data_tvalid !== 1'b1 || m_axis_data_tdata !== 16'd1) begin
                    n_errors++;
                    $display("FAIL stall_hold_%0d: got v=%b d=%0d expected v=1 d=1", k, m_axis_data_tvalid, m_axis_data_tdata);
                end
            end
        end
        s_axis_data_tvalid = 1'b0;
        tick();
        n_checks++;
        if (fill_level !== 5'd16) begin n_errors++; $display("FAIL bp_fill: got %0d expected 16", fill_level); end
        n_checks++;
        if (ovf_flag !== 1'b0) begin n_errors++; $display("FAIL bp_ovf: got %b expected 0", ovf_flag); end
        m_axis_data_tready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            n_checks++;
            if (m_axis_data_tvalid !== 1'b1 || m_axis_data_tdata !== 16'(k)) begin
                n_errors++;
                $display("FAIL bp_drain_%0d: got v=%b d=%0d expected v=1 d=%0d", k, m_axis_data_tvalid, m_axis_data_tdata, k);
            end
            tick();
        end
        n_checks++;
        if (m_axis_data_tvalid !== 1'b0 || fill_level !== 5'd0) begin
            n_errors++;
            $display("FAIL bp_empty: got v=%b fill=%0d expected v=0 fill=0", m_axis_data_tvalid, fill_level);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        m_axis_data_tready = 1'b0;
        push_seq(1, 16);
        push_seq(100, 3);
        tick();
        n_checks++;
        if (ovf_flag !== 1'b1) begin n_errors++; $display("FAIL ovf_set: got %b expected 1", ovf_flag); end
        n_checks++;
        if (fill_level !== 5'd16) begin n_errors++; $display("FAIL ovf_fill: got %0d expected 16", fill_level); end
`ifdef FIR_SINK_STATS_EN
        n_checks++;
        if (drop_count !== 16'd3) begin n_errors++; $display("FAIL ovf_drop_count: got %0d expected 3", drop_count); end
`endif
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_checks++;
        if (ovf_flag !== 1'b0) begin n_errors++; $display("FAIL ovf_clear: got %b expected 0", ovf_flag); end
`ifdef FIR_SINK_STATS_EN
        n_checks++;
        if (drop_count !== 16'd0) begin n_errors++; $display("FAIL ovf_clear_count: got %0d expected 0", drop_count); end
`endif
        // Drop on the same edge as a clear: flag must stay set.
        push_seq(200, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_checks++;
        if (ovf_flag !== 1'b1) begin n_errors++; $display("FAIL ovf_set_wins: got %b expected 1", ovf_flag); end
`ifdef FIR_SINK_STATS_EN
        n_checks++;
        if (drop_count !== 16'd1) begin n_errors++; $display("FAIL ovf_set_wins_count: got %0d expected 1", drop_count); end
`endif
        m_axis_data_tready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            n_checks++;
            if (m_axis_data_tvalid !== 1'b1 || m_axis_data_tdata !== 16'(k)) begin
                n_errors++;
                $display("FAIL ovf_drain_%0d: got v=%b d=%0d expected v=1 d=%0d", k, m_axis_data_tvalid, m_axis_data_tdata, k);
            end
            tick();
        end
        n_checks++;
        if (m_axis_data_tvalid !== 1'b0) begin n_errors++; $display("FAIL ovf_no_dropped: got tvalid %b expected 0", m_axis_data_tvalid); end
    endtask

    task automatic test_full_pop();
        do_reset();
        m_axis_data_tready = 1'b0;
        push_seq(1, 16);
        tick();
        push_seq(17, 1);
        m_axis_data_tready = 1'b1;
        tick();
        n_checks++;
        if (fill_level !== 5'd16) begin n_errors++; $display("FAIL fullpop_fill: got %0d expected 16", fill_level); end
        n_checks++;
        if (ovf_flag !== 1'b0) begin n_errors++; $display("FAIL fullpop_ovf: got %b expected 0", ovf_flag); end
        for (int k = 2; k <= 17; k++) begin
            n_checks++;
            if (m_axis_data_tvalid !== 1'b1 || m_axis_data_tdata !== 16'(k)) begin
                n_errors++;
                $display("FAIL fullpop_drain_%0d: got v=%b d=%0d expected v=1 d=%0d", k, m_axis_data_tvalid, m_axis_data_tdata, k);
            end
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        m_axis_data_tready = 1'b0;
        push_seq(1, 7);
        tick();
        n_checks++;
        if (fill_level !== 5'd7) begin n_errors++; $display("FAIL mid_fill_before: got %0d expected 7", fill_level); end
        #2;
        areset = 1'b1;
        #1;
        n_checks++;
        if (m_axis_data_tvalid !== 1'b0 || fill_level !== 5'd0) begin
            n_errors++;
            $display("FAIL mid_async: got v=%b fill=%0d expected v=0 fill=0", m_axis_data_tvalid, fill_level);
        end
        @(posedge aclk);
        #1;
        areset = 1'b0;
        model_reset();
        m_axis_data_tready = 1'b1;
        s_axis_data_tvalid = 1'b1;
        s_axis_data_tdata  = 34'd65536;
        tick();
        s_axis_data_tvalid = 1'b0;
        tick();
        n_checks++;
        if (m_axis_data_tvalid !== 1'b1 || m_axis_data_tdata !== 16'd2) begin
            n_errors++;
            $display("FAIL mid_after: got v=%b d=%0d expected v=1 d=2", m_axis_data_tvalid, m_axis_data_tdata);
        end
    endtask

    task automatic test_random();
        int r;
        int mode;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            s_axis_data_tvalid = ($urandom_range(0, 9) < 8);
            mode = int'($urandom_range(0, 2));
            if (mode == 0) begin
                r = int'($urandom_range(0, 2097152)) - 1048576;
                s_axis_data_tdata = 34'(r);
            end else if (mode == 1) begin
                r = (int'($urandom_range(0, 200)) - 100) * 32768 + 16384;
                s_axis_data_tdata = 34'(r);
            end else begin
                r = int'($urandom_range(0, 3));
                s_axis_data_tdata = {2'(r), 32'($urandom)};
            end
            if ((c % 100) < 40) m_axis_data_tready = ($urandom_range(0, 9) < 2);
            else m_axis_data_tready = ($urandom_range(0, 9) < 7);
            ovf_clr = ($urandom_range(0, 24) == 0);
            tick();
            n_checks++;
            if (m_axis_data_tvalid !== (mq.size() != 0)) begin
                n_errors++;
                $display("FAIL rnd_tvalid c=%0d: got %b expected %0d", c, m_axis_data_tvalid, mq.size() != 0);
            end
            n_checks++;
            if (fill_level !== 5'(mq.size())) begin
                n_errors++;
                $display("FAIL rnd_fill c=%0d: got %0d expected %0d", c, fill_level, mq.size());
            end
            if (mq.size() != 0) begin
                n_checks++;
                if (m_axis_data_tdata !== 16'(mq[0])) begin
                    n_errors++;
                    $display("FAIL rnd_tdata c=%0d: got %0d expected %0d", c, $signed(m_axis_data_tdata), mq[0]);
                end
            end
            n_checks++;
            if (ovf_flag !== m_ovf) begin
                n_errors++;
                $display("FAIL rnd_ovf c=%0d: got %b expected %b", c, ovf_flag, m_ovf);
            end
`ifdef FIR_SINK_STATS_EN
            n_checks++;
            if (drop_count !== 16'(m_dc)) begin
                n_errors++;
                $display("FAIL rnd_drop_count c=%0d: got %0d expected %0d", c, drop_count, m_dc);
            end
`endif
        end
        ovf_clr = 1'b0;
        s_axis_data_tvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
